// File: rtl/fetch_decode_queue_pkg.sv
// Shared core definitions for the fetch/decode boundary: instruction width,
// 32-bit encoding marker and the major opcodes used by decode and immediate gen.
package fetch_decode_queue_pkg;

  localparam int INS_W = 32;
  localparam logic [1:0] ENC_32 = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OPV    = 7'h57;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  function automatic logic is_illegal(input logic [INS_W-1:0] word);
    return word[1:0] != ENC_32;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one async read port.
// Write lands on the clock edge; read is combinational; no flow control here.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk_in,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are don't-care after reset/flush; valid state lives in the pointers.
  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch->decode instruction queue; 1-cycle latency (0 with FETCH_QUEUE_BYPASS_EN on empty).
// Backpressure: registered fetch ready = !full; flush drops all entries next edge.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     fq_flush_in,
  input  logic                     fq_fetch_valid_in,
  input  logic [INS_W-1:0]         fq_fetch_ins_in,
  input  logic [PC_W-1:0]          fq_fetch_pc_in,
  output logic                     fq_fetch_ready_out,
  output logic                     fq_dec_valid_out,
  input  logic                     fq_dec_ready_in,
  output logic [PC_W-1:0]          fq_dec_pc_out,
  output logic [6:0]               fq_dec_opcode_out,
  output logic [24:0]              fq_dec_ins_out,
  output logic                     fq_dec_illegal_out,
  output logic [$clog2(DEPTH):0]   fq_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PC_W + INS_W;

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ready_q;
  logic [ENT_W-1:0] head_ent, sel_ent;
  logic             empty, bypass, push_acc, wr_en, pop_st;

  assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass  = empty & fq_fetch_valid_in & ~fq_flush_in;
  assign sel_ent = bypass ? {fq_fetch_pc_in, fq_fetch_ins_in} : head_ent;
`else
  assign bypass  = 1'b0;
  assign sel_ent = head_ent;
`endif

  // A bypassed entry consumed this cycle never touches storage.
  assign push_acc = fq_fetch_valid_in & ready_q & ~fq_flush_in;
  assign wr_en    = push_acc & ~(bypass & fq_dec_ready_in);
  assign pop_st   = ~empty & fq_dec_ready_in & ~fq_flush_in;

  always_comb begin
    count_nxt = count;
    if (fq_flush_in) count_nxt = '0;
    else             count_nxt = count + CNT_W'(wr_en) - CNT_W'(pop_st);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt != CNT_W'(DEPTH));
      if (fq_flush_in) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (wr_en)  tail <= tail + 1'b1;
        if (pop_st) head <= head + 1'b1;
      end
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_storage (
    .clk_in (clk_in),
    .we     (wr_en),
    .waddr  (tail),
    .wdata  ({fq_fetch_pc_in, fq_fetch_ins_in}),
    .raddr  (head),
    .rdata  (head_ent)
  );

  assign fq_fetch_ready_out = ready_q;
  assign fq_dec_valid_out   = ~empty | bypass;
  assign fq_count_out       = count;

  // Outputs are held at zero whenever no entry is presented.
  always_comb begin
    fq_dec_pc_out      = '0;
    fq_dec_opcode_out  = '0;
    fq_dec_ins_out     = '0;
    fq_dec_illegal_out = 1'b0;
    if (fq_dec_valid_out) begin
      fq_dec_pc_out      = sel_ent[ENT_W-1:INS_W];
      fq_dec_opcode_out  = sel_ent[6:0];
      fq_dec_ins_out     = sel_ent[INS_W-1:7];
      fq_dec_illegal_out = is_illegal(sel_ent[INS_W-1:0]);
    end
  end

endmodule
